// File: rtl/mult32_seq_pkg.sv
// mult32_seq_pkg
//   Shared definitions for the iterative shift-add multiplier:
//   - DEF_WIDTH / DEF_CNT_W : default operand width and iteration counter width
//   - MULT_LATENCY          : start-accept edge to done cycle without early
//                             termination (WIDTH + 2); used by stall logic
//   - state_t               : FSM state encoding
//   Optional feature macro used by the files importing this package:
//   MULT32_EARLY_TERM_EN.
package mult32_seq_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CNT_W    = 6;
  localparam int MULT_LATENCY = DEF_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult32_datapath.sv
// mult32_datapath
//   Operand / accumulator registers, the add-shift step, the sign fix-up and
//   the result registers of the sequential multiplier. Sequencing comes from
//   the ld / step / fix strobes generated by mult32_seq.
//   Ports:
//     clk, reset_n        clock, synchronous active-low reset
//     ld                  latch operand magnitudes and sign, clear accumulator
//     step                perform one add-shift iteration
//     fix                 apply sign, compute overflow, register results
//     is_signed, a, b     operands (sampled on ld only)
//     cnt, early          only with MULT32_EARLY_TERM_EN: iteration index in,
//                         "remaining multiplier bits are zero" flag out
//     result_lo/hi, ovf   registered product and overflow flag
module mult32_datapath #(
  parameter int WIDTH = 32
`ifdef MULT32_EARLY_TERM_EN
  ,
  parameter int CNT_W = 6
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic             step,
  input  logic             fix,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT32_EARLY_TERM_EN
  input  logic [CNT_W-1:0] cnt,
  output logic             early,
`endif
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             ovf
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;      // upper half: partial product, lower half: multiplier
  logic               neg;
  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;      // carry + upper half
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic               ovf_c;

`ifdef MULT32_EARLY_TERM_EN
  logic [WIDTH-1:0]   mplier;   // shadow of the not-yet-consumed multiplier bits
  logic [CNT_W-1:0]   rem;
`endif

  always_comb begin
    // The most negative value maps to itself, which reads correctly as 2^(W-1)
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    // {carry, upper, lower} is 2*WIDTH+1 bits; the right shift drops the
    // consumed multiplier LSB so the carry lands in the top product bit.
    acc_step = {sum, acc[WIDTH-1:1]};
    acc_next = acc_step;
`ifdef MULT32_EARLY_TERM_EN
    early = (mplier[WIDTH-1:1] == '0);
    rem   = CNT_W'(WIDTH - 1) - cnt;
    // Barrel-align: the skipped iterations would only have shifted right.
    if (early) acc_next = acc_step >> rem;
`endif
    prod  = neg ? -acc : acc;
    ovf_c = sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                : (prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand     <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      sgn       <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      ovf       <= 1'b0;
`ifdef MULT32_EARLY_TERM_EN
      mplier    <= '0;
`endif
    end else begin
      if (ld) begin
        mcand  <= a_mag;
        acc    <= {{WIDTH{1'b0}}, b_mag};
        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        sgn    <= is_signed;
`ifdef MULT32_EARLY_TERM_EN
        mplier <= b_mag;
`endif
      end else if (step) begin
        acc    <= acc_next;
`ifdef MULT32_EARLY_TERM_EN
        mplier <= mplier >> 1;
`endif
      end
      if (fix) begin
        result_hi <= prod[2*WIDTH-1:WIDTH];
        result_lo <= prod[WIDTH-1:0];
        ovf       <= ovf_c;
      end
    end
  end

endmodule

// File: rtl/mult32_seq.sv
// mult32_seq
//   Iterative shift-add WIDTH x WIDTH multiplier (signed or unsigned) for the
//   ALU execute stage. result_lo feeds the ALU result mux.
//   Optional feature macro: MULT32_EARLY_TERM_EN (leave RUN as soon as the
//   remaining multiplier bits are zero; results unchanged, latency shorter).
//   Ports (bit 0 is the MSB on all vectors):
//     clk, reset_n          clock, synchronous active-low reset
//     start, is_signed      request pulse and operand signedness
//     a, b                  multiplicand / multiplier
//     busy, done            handshake status
//     result_lo, result_hi  product words; hold until the next FIX cycle
//     ovf                   product does not fit in WIDTH bits
//     dbg_state             current FSM state
//   Handshake: start is accepted only in IDLE or DONE and is otherwise
//   dropped (never queued); operands are sampled on the accepting edge only.
//   busy is high in RUN and FIX; done is high for exactly the one DONE cycle,
//   in which busy is low and a new start may be accepted back-to-back.
module mult32_seq
  import mult32_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic           busy,
  output logic           done,
  output logic [0:WIDTH-1] result_lo,
  output logic [0:WIDTH-1] result_hi,
  output logic           ovf,
  output state_t         dbg_state
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             ld;
  logic             step;
  logic             fix;
  logic             last_iter;
  logic             early_term;

  mult32_datapath #(
    .WIDTH(WIDTH)
`ifdef MULT32_EARLY_TERM_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_dp (
    .clk       (clk),
    .reset_n   (reset_n),
    .ld        (ld),
    .step      (step),
    .fix       (fix),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
`ifdef MULT32_EARLY_TERM_EN
    .cnt       (cnt),
    .early     (early_term),
`endif
    .result_lo (result_lo),
    .result_hi (result_hi),
    .ovf       (ovf)
  );

`ifndef MULT32_EARLY_TERM_EN
  assign early_term = 1'b0;
`endif

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (ld)        cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    step     = 1'b0;
    fix      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ld       = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_iter || early_term) state_nx = ST_FIX;
      end
      ST_FIX: begin
        fix      = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          ld       = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_RUN) || (state == ST_FIX);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq
//   Self-checking bench for mult32_seq. Expected products come from plain
//   64-bit arithmetic; expected latency from the iteration count implied by
//   the multiplier magnitude (MULT32_EARLY_TERM_EN) or MULT_LATENCY.
module tb_mult32_seq;
  import mult32_seq_pkg::*;

  localparam int W       = DEF_WIDTH;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  state_t       dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W:0] exp_q[$];   // {ovf, hi, lo}
  logic [2*W:0] last_exp = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mult32_seq #(.WIDTH(W), .CNT_W(DEF_CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input bit sg);
    logic [2*W-1:0] p;
    logic           o;
    if (sg) p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    else    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    if (sg) o = (p[2*W-1:W] != {W{p[W-1]}});
    else    o = (p[2*W-1:W] != '0);
    return {o, p};
  endfunction

  function automatic int model_lat(input logic [W-1:0] y, input bit sg);
`ifdef MULT32_EARLY_TERM_EN
    logic [W-1:0] m;
    int           it;
    m  = (sg && y[W-1]) ? -y : y;
    it = 1;
    for (int i = 0; i < W; i++) if (m[i]) it = i + 1;
    return it + 2;
`else
    if (sg && y[W-1]) return MULT_LATENCY;
    return MULT_LATENCY;
`endif
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; start is sampled on the following posedge.
  // pulse_at != 0 re-asserts start (with other operands) in that busy cycle.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit sg,
                        input int pulse_at);
    int           lat;
    bit           seen;
    bit           bad_busy;
    bit           bad_hold;
    logic [2*W:0] e;
    lat = model_lat(bb, sg);
    exp_q.push_back(model(aa, bb, sg));
    a = aa; b = bb; is_signed = sg; start = 1'b1;
    @(posedge clk);
    seen = 0; bad_busy = 0; bad_hold = 0;
    for (int k = 1; k <= TIMEOUT && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
      end
      if (pulse_at != 0 && k == pulse_at) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end
      if (pulse_at != 0 && k == pulse_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1;
        e = exp_q.pop_front();
        n_cmp++;
        if (k != lat) begin
          n_err++;
          $display("FAIL latency: a=%h b=%h s=%0d got %0d cycles want %0d", aa, bb, sg, k, lat);
        end
        n_cmp++;
        if ({ovf, result_hi, result_lo} !== e) begin
          n_err++;
          $display("FAIL product: a=%h b=%h s=%0d got ovf=%b hi=%h lo=%h want ovf=%b hi=%h lo=%h",
                   aa, bb, sg, ovf, result_hi, result_lo, e[2*W], e[2*W-1:W], e[W-1:0]);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_in_done: got %b want 0", busy);
        end
        last_exp = e;
      end else begin
        if (busy !== 1'b1) bad_busy = 1;
        if ({ovf, result_hi, result_lo} !== last_exp) bad_hold = 1;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles (a=%h b=%h)", TIMEOUT, aa, bb);
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (bad_busy) begin
      n_err++;
      $display("FAIL busy_window: busy low before done (a=%h b=%h) want high", aa, bb);
    end
    n_cmp++;
    if (bad_hold) begin
      n_err++;
      $display("FAIL result_hold: results changed before done (a=%h b=%h)", aa, bb);
    end
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (ovf !== 1'b0)    begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    n_cmp++; if (result_lo !== '0) begin n_err++; $display("FAIL rst_lo: got %h want 0", result_lo); end
    n_cmp++; if (result_hi !== '0) begin n_err++; $display("FAIL rst_hi: got %h want 0", result_hi); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    reset_n = 1'b1;
    last_exp = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] da[8];
    logic [W-1:0] db[8];
    bit           ds[8];
    da = '{32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h8000_0000, 32'd7, 32'd7, 32'h0000_0000};
    db = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'd1, 32'h0001_0000, 32'h8765_4321};
    ds = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_op(da[i], db[i], ds[i], 0);
      @(negedge clk);
      check_idle("done_one_cycle");
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) rb = rb >> $urandom_range(0, W - 1);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op(32'd12, 32'd11, 1'b0, 0);
    run_op(32'hFFFF_FFF0, 32'd9, 1'b1, 0);
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 0);
    @(negedge clk);
    check_idle("b2b_idle");
  endtask

  task automatic test_ignore_start();
    bit extra;
    run_op(32'd1000, 32'hFFFF_FFFB, 1'b1, 5);
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra = 1;
    end
    n_cmp++;
    if (extra) begin
      n_err++;
      $display("FAIL ignored_start: busy/done seen after single op, want none");
    end
  endtask

  task automatic test_reset_mid_run();
    bit extra;
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++;
    if ({ovf, result_hi, result_lo} !== '0) begin
      n_err++;
      $display("FAIL midrst_results: got ovf=%b hi=%h lo=%h want 0", ovf, result_hi, result_lo);
    end
    last_exp = '0;
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) extra = 1;
    end
    n_cmp++;
    if (extra) begin
      n_err++;
      $display("FAIL midrst_no_done: done seen after reset, want none");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_reset_mid_run();
    run_op(32'd6, 32'd7, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
